// File: rtl/uart_bench_pkg.sv
// Shared types and elaboration-time helpers for the bench-side UART agent.
// Holds the FSM state encoding, the RX FIFO entry layout and the parameter legality checks.
package uart_bench_pkg;

  localparam int MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Data is always stored at full width; bits above DATA_BITS stay zero.
  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  function automatic int frame_cycles(input int clk_div, input int data_bits,
                                      input int parity_en, input int stop_bits);
    return (1 + data_bits + parity_en + stop_bits) * clk_div;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int clk_div, input int data_bits,
                                      input int parity_en, input int parity_odd,
                                      input int stop_bits, input int rx_depth);
    return (clk_div >= 4) && ((clk_div % 2) == 0) &&
           (data_bits >= 5) && (data_bits <= MAX_DATA_BITS) &&
           (parity_en == 0 || parity_en == 1) &&
           (parity_odd == 0 || parity_odd == 1) &&
           (stop_bits == 1 || stop_bits == 2) &&
           (rx_depth >= 2) && is_pow2(rx_depth);
  endfunction

endpackage

// File: rtl/uart_bench_fifo.sv
// Generic synchronous FIFO with occupancy counter; a push into a full FIFO is dropped
// and latches a sticky overflow flag, unless a pop in the same cycle frees the slot.
module uart_bench_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_bench_agent.sv
// Bench-side UART agent: serialises host bytes, deserialises the DUT's serial output
// into a flagged valid/ready stream, and keeps a free-running 64-bit cycle counter.
module uart_bench_agent
  import uart_bench_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int RX_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overflow,
  output logic [63:0]          cycles,
  output logic                 busy
);

  localparam bit PARAMS_OK = params_legal(CLK_DIV, DATA_BITS, PARITY_EN, PARITY_ODD,
                                          STOP_BITS, RX_DEPTH);

  if (!PARAMS_OK) begin : g_bad_params
    $error("uart_bench_agent: illegal parameter combination");
  end

  localparam int       DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic       ODD_BIT   = 1'(PARITY_ODD);

  always_ff @(posedge clock) begin
    if (reset) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 64'd1;
    end
  end

  uart_state_e          tx_state;
  logic [DIV_W-1:0]     tx_div;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_end;

  assign tx_end = (tx_div == DIV_LAST);

  // TX: the line and tx_ready are registered, so a handshake at one edge drives the
  // start bit right after it and tx_ready returns right after the last stop cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= IDLE;
      uart_txd <= 1'b1;
      tx_ready <= 1'b0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      if (tx_state != IDLE) begin
        tx_div <= tx_end ? '0 : tx_div + 1'b1;
      end
      case (tx_state)
        IDLE: begin
          uart_txd <= 1'b1;
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            tx_state <= START;
            uart_txd <= 1'b0;
            tx_ready <= 1'b0;
            tx_shift <= tx_data;
            tx_par   <= (^tx_data) ^ ODD_BIT;
            tx_div   <= '0;
          end
        end
        START: begin
          if (tx_end) begin
            tx_state <= DATA;
            uart_txd <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
          end
        end
        DATA: begin
          if (tx_end) begin
            if (tx_bit == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx_state <= PARITY;
                uart_txd <= tx_par;
              end else begin
                tx_state <= STOP;
                uart_txd <= 1'b1;
                tx_bit   <= '0;
              end
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              uart_txd <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end
        end
        PARITY: begin
          if (tx_end) begin
            tx_state <= STOP;
            uart_txd <= 1'b1;
            tx_bit   <= '0;
          end
        end
        STOP: begin
          if (tx_end) begin
            if (tx_bit == STOP_LAST) begin
              tx_state <= IDLE;
              tx_ready <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end
        end
        default: begin
          tx_state <= IDLE;
          uart_txd <= 1'b1;
        end
      endcase
    end
  end

  logic rx_s1;
  logic rx_s2;
  logic rx_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  uart_state_e              rx_state;
  logic [DIV_W-1:0]         rx_div;
  logic [2:0]               rx_bit;
  logic [MAX_DATA_BITS-1:0] rx_shift;
  logic                     rx_perr;
  logic                     rx_push;
  rx_entry_t                rx_entry;
  logic                     rx_end;

  assign rx_end = (rx_div == DIV_LAST);

  // RX: start is re-checked half a bit in to reject glitches, then every bit is
  // sampled mid-bit; the frame is pushed without waiting out the stop bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= IDLE;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_perr  <= 1'b0;
      rx_push  <= 1'b0;
      rx_entry <= '0;
    end else begin
      rx_push <= 1'b0;
      if (rx_state != IDLE) begin
        rx_div <= rx_div + 1'b1;
      end
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= START;
            rx_div   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
          end
        end
        START: begin
          if (rx_div == HALF_LAST) begin
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (rx_end) begin
            rx_div                    <= '0;
            rx_shift[DATA_BITS-1]     <= rx_s2;
            rx_shift[DATA_BITS-2:0]   <= rx_shift[DATA_BITS-1:1];
            if (rx_bit == BIT_LAST) begin
              rx_state <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end
        end
        PARITY: begin
          if (rx_end) begin
            rx_div   <= '0;
            rx_perr  <= (^rx_shift) ^ ODD_BIT ^ rx_s2;
            rx_state <= STOP;
          end
        end
        STOP: begin
          if (rx_end) begin
            rx_div   <= '0;
            rx_push  <= 1'b1;
            rx_entry <= '{frame_err: ~rx_s2, parity_err: rx_perr, data: rx_shift};
            rx_state <= IDLE;
          end
        end
        default: begin
          rx_state <= IDLE;
        end
      endcase
    end
  end

  rx_entry_t rx_head;
  logic      fifo_empty;
  logic      fifo_full;

  uart_bench_fifo #(
    .WIDTH($bits(rx_entry_t)),
    .DEPTH(RX_DEPTH)
  ) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (rx_push),
    .wdata   (rx_entry),
    .pop     (rx_ready),
    .rdata   (rx_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .overflow(rx_overflow)
  );

  assign rx_valid      = !fifo_empty;
  assign rx_data       = rx_head.data[DATA_BITS-1:0];
  assign rx_parity_err = rx_head.parity_err;
  assign rx_frame_err  = rx_head.frame_err;

  assign busy = (tx_state != IDLE) || (rx_state != IDLE) || rx_push || !fifo_empty || fifo_full;

endmodule

// File: tb/tb_uart_bench_agent.sv
// Directed-plus-random bench for uart_bench_agent: one instance without parity and one
// with even parity, both at 4 clocks per bit, checked against a frame-level model.
module tb_uart_bench_agent;

  localparam int DIV = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic        a_tx_valid, a_tx_ready, a_txd, a_rxd, a_rx_valid, a_rx_ready;
  logic        a_perr, a_ferr, a_ovf, a_busy;
  logic [7:0]  a_tx_data, a_rx_data;
  logic [63:0] a_cycles;

  logic        b_tx_valid, b_tx_ready, b_txd, b_rxd, b_rx_valid, b_rx_ready;
  logic        b_perr, b_ferr, b_ovf, b_busy;
  logic [7:0]  b_tx_data, b_rx_data;
  logic [63:0] b_cycles;

  logic loop_a, loop_b, drv_a, drv_b;
  assign a_rxd = loop_a ? a_txd : drv_a;
  assign b_rxd = loop_b ? b_txd : drv_b;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] cyc_model;

  uart_bench_agent #(.CLK_DIV(DIV)) dut_a (
    .clock(clock), .reset(reset),
    .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_data(a_tx_data),
    .uart_txd(a_txd), .uart_rxd(a_rxd),
    .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_data(a_rx_data),
    .rx_parity_err(a_perr), .rx_frame_err(a_ferr), .rx_overflow(a_ovf),
    .cycles(a_cycles), .busy(a_busy)
  );

  uart_bench_agent #(.CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clock(clock), .reset(reset),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data),
    .uart_txd(b_txd), .uart_rxd(b_rxd),
    .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data),
    .rx_parity_err(b_perr), .rx_frame_err(b_ferr), .rx_overflow(b_ovf),
    .cycles(b_cycles), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    cyc_model = reset ? 64'd0 : cyc_model + 64'd1;
    #1;
  endtask

  // Line levels of one frame, index 0 first on the wire.
  function automatic logic [11:0] frame_bits(input logic [7:0] d, input bit par_en,
                                             input bit stop_val, input bit flip);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = d[i];
    if (par_en) f[9] = (^d) ^ flip;
    f[9 + int'(par_en)] = stop_val;
    return f;
  endfunction

  task automatic send(input bit sel, input logic [7:0] d, input bit wave);
    logic [11:0] f;
    int          guard;
    guard = 0;
    while (!(sel ? b_tx_ready : a_tx_ready) && guard < 200) begin
      applyStimulus();
      guard++;
    end
    check("tx_ready_wait", sel ? b_tx_ready : a_tx_ready, 1);
    if (sel) begin b_tx_data = d; b_tx_valid = 1'b1; end
    else     begin a_tx_data = d; a_tx_valid = 1'b1; end
    applyStimulus();
    a_tx_valid = 1'b0;
    b_tx_valid = 1'b0;
    a_tx_data  = 8'($urandom);
    b_tx_data  = 8'($urandom);
    f = frame_bits(d, sel, 1'b1, 1'b0);
    for (int k = 0; k < (10 + int'(sel)) * DIV; k++) begin
      if (wave) begin
        check("tx_line", sel ? b_txd : a_txd, f[k / DIV]);
        check("tx_ready_in_frame", sel ? b_tx_ready : a_tx_ready, 0);
      end
      applyStimulus();
    end
    if (wave) check("tx_ready_back", sel ? b_tx_ready : a_tx_ready, 1);
  endtask

  task automatic drive_frame(input bit sel, input logic [7:0] d, input bit flip, input bit stop_val);
    logic [11:0] f;
    f = frame_bits(d, sel, stop_val, flip);
    for (int k = 0; k < (10 + int'(sel)) * DIV; k++) begin
      if (sel) drv_b = f[k / DIV];
      else     drv_a = f[k / DIV];
      applyStimulus();
    end
    drv_a = 1'b1;
    drv_b = 1'b1;
  endtask

  task automatic checkOutput(input bit sel, input logic [9:0] exp, input string tag);
    check({tag, "_valid"}, sel ? b_rx_valid : a_rx_valid, 1);
    check(tag, sel ? {b_ferr, b_perr, b_rx_data} : {a_ferr, a_perr, a_rx_data}, exp);
    if (sel) b_rx_ready = 1'b1;
    else     a_rx_ready = 1'b1;
    applyStimulus();
    a_rx_ready = 1'b0;
    b_rx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] bytes [4];
    logic [7:0] r;

    reset = 1'b1;
    a_tx_valid = 1'b0; b_tx_valid = 1'b0;
    a_tx_data = 8'h00; b_tx_data = 8'h00;
    a_rx_ready = 1'b0; b_rx_ready = 1'b0;
    loop_a = 1'b0; loop_b = 1'b0; drv_a = 1'b1; drv_b = 1'b1;
    cyc_model = 64'd0;
    applyStimulus();
    applyStimulus();

    check("rst_txd", a_txd, 1);
    check("rst_tx_ready", a_tx_ready, 0);
    check("rst_rx_valid", a_rx_valid, 0);
    check("rst_perr", a_perr, 0);
    check("rst_ferr", a_ferr, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_cycles", a_cycles, 0);
    check("rst_busy", a_busy, 0);
    check("rst_b_txd", b_txd, 1);

    reset = 1'b0;
    applyStimulus();
    check("post_rst_ready", a_tx_ready, 1);
    check("post_rst_cycles", a_cycles, cyc_model);

    $display("[TB] TX waveform 0xA5");
    send(1'b0, 8'hA5, 1'b1);
    check("cycles_a", a_cycles, cyc_model);

    $display("[TB] loopback back-to-back on A");
    bytes[0] = 8'h3C; bytes[1] = 8'hC3; bytes[2] = 8'($urandom); bytes[3] = 8'($urandom);
    loop_a = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, bytes[i], i < 2);
    loop_a = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus();
    check("lb_ovf", a_ovf, 0);
    for (int i = 0; i < 4; i++) checkOutput(1'b0, {2'b00, bytes[i]}, "lb_entry");
    check("lb_empty", a_rx_valid, 0);

    $display("[TB] parity agent");
    send(1'b1, 8'h07, 1'b1);
    r = 8'($urandom);
    drive_frame(1'b1, r, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput(1'b1, {2'b01, r}, "par_flip");
    r = 8'($urandom);
    drive_frame(1'b1, r, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput(1'b1, {2'b00, r}, "par_good");
    bytes[0] = 8'($urandom); bytes[1] = 8'($urandom);
    loop_b = 1'b1;
    send(1'b1, bytes[0], 1'b0);
    send(1'b1, bytes[1], 1'b0);
    loop_b = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput(1'b1, {2'b00, bytes[0]}, "par_lb0");
    checkOutput(1'b1, {2'b00, bytes[1]}, "par_lb1");

    $display("[TB] frame error and glitch");
    r = 8'($urandom);
    drive_frame(1'b0, r, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput(1'b0, {2'b10, r}, "frame_err");
    check("frame_err_empty", a_rx_valid, 0);
    drv_a = 1'b0;
    applyStimulus();
    drv_a = 1'b1;
    for (int i = 0; i < 3 * DIV; i++) applyStimulus();
    check("glitch_rx_valid", a_rx_valid, 0);
    check("glitch_busy", a_busy, 0);

    $display("[TB] overflow");
    for (int i = 1; i <= 5; i++) drive_frame(1'b0, 8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus();
    check("ovf_set", a_ovf, 1);
    for (int i = 1; i <= 4; i++) checkOutput(1'b0, {2'b00, 8'(i)}, "ovf_entry");
    check("ovf_drained", a_rx_valid, 0);
    check("ovf_sticky", a_ovf, 1);
    check("cycles_b", b_cycles, cyc_model);

    $display("[TB] reset mid-frame");
    check("mid_ready", a_tx_ready, 1);
    a_tx_data  = 8'($urandom);
    a_tx_valid = 1'b1;
    applyStimulus();
    a_tx_valid = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus();
    check("mid_busy", a_busy, 1);
    reset = 1'b1;
    applyStimulus();
    check("mid_rst_txd", a_txd, 1);
    check("mid_rst_cycles", a_cycles, 0);
    check("mid_rst_ready", a_tx_ready, 0);
    check("mid_rst_ovf", a_ovf, 0);
    check("mid_rst_busy", a_busy, 0);
    applyStimulus();
    check("mid_rst_ready2", a_tx_ready, 0);
    reset = 1'b0;
    applyStimulus();
    check("mid_rel_ready", a_tx_ready, 1);
    check("mid_rel_cycles", a_cycles, cyc_model);
    check("mid_rel_txd", a_txd, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
